// File: rtl/data_cache_mem_pkg.sv
// Shared FSM encoding, request-type constants and sizing helper for the
// data cache memory responder.
package data_cache_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_READ_WAIT   = 3'd1,
    ST_READ_BURST  = 3'd2,
    ST_WRITE_BURST = 3'd3,
    ST_WRITE_WAIT  = 3'd4,
    ST_WRITE_ACK   = 3'd5
  } state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  function automatic int offset_width(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/data_cache_mem_array.sv
// Single-port synchronous 32-bit RAM, 2^ADDR_WIDTH words, registered read data.
module data_cache_mem_array #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data_p1
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wr_data;
      else    rd_data_p1 <= mem[addr];
    end
  end

endmodule

// File: rtl/data_cache_memory_responder.sv
// Memory-side responder for data cache line refills and writebacks.
// Optional macro CRITICAL_WORD_FIRST_EN: read bursts start at the requested word.
module data_cache_memory_responder
  import data_cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_REQ_VALID,
  output logic        MEM_REQ_READY,
  input  logic        MEM_REQ_WRITE,
  input  logic [31:0] MEM_REQ_ADDRESS,
  input  logic        MEM_WRITE_DATA_VALID,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic        MEM_WRITE_DATA_READY,
  output logic        MEM_READ_DATA_VALID,
  output logic [31:0] MEM_READ_DATA,
  output logic        MEM_READ_LAST,
  output logic        MEM_WRITE_DONE
);

  localparam int OFF_W  = offset_width(LINE_WORDS);
  localparam int LINE_W = ADDR_WIDTH - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_t            state, state_nxt;
  logic [OFF_W-1:0]  beat, beat_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic [LINE_W-1:0] line_q;

  logic [ADDR_WIDTH-1:0] req_word;
  logic [LINE_W-1:0]     req_line;
  logic [OFF_W-1:0]      req_off;
  logic                  accept;
  logic                  wr_beat;

  logic                  rd_issue;
  logic [LINE_W-1:0]     rd_line;
  logic [OFF_W-1:0]      rd_idx;
  logic [OFF_W-1:0]      rd_start;
  logic [OFF_W-1:0]      rd_off;

  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           rd_data_p1;
  logic                  unused_addr;

  assign req_word = MEM_REQ_ADDRESS[ADDR_WIDTH+1:2];
  assign req_line = req_word[ADDR_WIDTH-1:OFF_W];
  assign req_off  = req_word[OFF_W-1:0];

  assign accept  = MEM_REQ_READY & MEM_REQ_VALID;
  assign wr_beat = (state == ST_WRITE_BURST) & MEM_WRITE_DATA_VALID;

  // Line base is captured at acceptance; it is datapath, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) line_q <= req_line;
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] start_off_q;

  always_ff @(posedge CLK) begin
    if (accept) start_off_q <= req_off;
  end

  assign rd_start    = (state == ST_IDLE) ? req_off : start_off_q;
  assign unused_addr = ^{MEM_REQ_ADDRESS[31:ADDR_WIDTH+2], MEM_REQ_ADDRESS[1:0]};
`else
  assign rd_start    = '0;
  assign unused_addr = ^{MEM_REQ_ADDRESS[31:ADDR_WIDTH+2], MEM_REQ_ADDRESS[1:0], req_off};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      beat    <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    lat_cnt_nxt = lat_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          beat_nxt = '0;
          if (MEM_REQ_WRITE == REQ_WRITE) begin
            state_nxt = ST_WRITE_BURST;
          end else if (LATENCY == 1) begin
            state_nxt = ST_READ_BURST;
          end else begin
            state_nxt   = ST_READ_WAIT;
            lat_cnt_nxt = LAT_INIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (lat_cnt == LAT_ONE) state_nxt = ST_READ_BURST;
        else                    lat_cnt_nxt = lat_cnt - 1'b1;
      end
      ST_READ_BURST: begin
        beat_nxt = beat + 1'b1;
        if (beat == LAST_BEAT) state_nxt = ST_IDLE;
      end
      ST_WRITE_BURST: begin
        if (wr_beat) begin
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            if (LATENCY == 1) begin
              state_nxt = ST_WRITE_ACK;
            end else begin
              state_nxt   = ST_WRITE_WAIT;
              lat_cnt_nxt = LAT_INIT;
            end
          end
        end
      end
      ST_WRITE_WAIT: begin
        if (lat_cnt == LAT_ONE) state_nxt = ST_WRITE_ACK;
        else                    lat_cnt_nxt = lat_cnt - 1'b1;
      end
      ST_WRITE_ACK: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Read issue runs one cycle ahead of the beat so the registered RAM output
  // lines up with MEM_READ_DATA_VALID.
  always_comb begin
    rd_issue = LOW;
    rd_line  = line_q;
    rd_idx   = '0;
    case (state)
      ST_IDLE: begin
        rd_line = req_line;
        if (accept && (MEM_REQ_WRITE == REQ_READ) && (LATENCY == 1)) rd_issue = HIGH;
      end
      ST_READ_WAIT: begin
        if (lat_cnt == LAT_ONE) rd_issue = HIGH;
      end
      ST_READ_BURST: begin
        if (beat != LAST_BEAT) begin
          rd_issue = HIGH;
          rd_idx   = beat + 1'b1;
        end
      end
      default: rd_issue = LOW;
    endcase
  end

  assign rd_off   = rd_idx + rd_start;
  assign ram_en   = wr_beat | rd_issue;
  assign ram_addr = wr_beat ? {line_q, beat} : {rd_line, rd_off};

  data_cache_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk        (CLK),
    .en         (ram_en),
    .we         (wr_beat),
    .addr       (ram_addr),
    .wr_data    (MEM_WRITE_DATA),
    .rd_data_p1 (rd_data_p1)
  );

  // Beat stage: outputs follow the registered state and RAM data.
  assign MEM_REQ_READY        = (state == ST_IDLE) & ~RST;
  assign MEM_WRITE_DATA_READY = (state == ST_WRITE_BURST);
  assign MEM_READ_DATA_VALID  = (state == ST_READ_BURST);
  assign MEM_READ_LAST        = (state == ST_READ_BURST) & (beat == LAST_BEAT);
  assign MEM_READ_DATA        = MEM_READ_DATA_VALID ? rd_data_p1 : 32'd0;
  assign MEM_WRITE_DONE       = (state == ST_WRITE_ACK);

endmodule

// File: tb/tb_data_cache_memory_responder.sv
// Randomized self-checking bench for data_cache_memory_responder against a
// word-array reference model of line reads and writes.
module tb_data_cache_memory_responder;

  localparam int AW  = 12;
  localparam int LW  = 4;
  localparam int LAT = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_REQ_VALID;
  logic        MEM_REQ_READY;
  logic        MEM_REQ_WRITE;
  logic [31:0] MEM_REQ_ADDRESS;
  logic        MEM_WRITE_DATA_VALID;
  logic [31:0] MEM_WRITE_DATA;
  logic        MEM_WRITE_DATA_READY;
  logic        MEM_READ_DATA_VALID;
  logic [31:0] MEM_READ_DATA;
  logic        MEM_READ_LAST;
  logic        MEM_WRITE_DONE;

  always #5 CLK = ~CLK;

  data_cache_memory_responder #(
    .ADDR_WIDTH (AW),
    .LINE_WORDS (LW),
    .LATENCY    (LAT)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .MEM_REQ_VALID        (MEM_REQ_VALID),
    .MEM_REQ_READY        (MEM_REQ_READY),
    .MEM_REQ_WRITE        (MEM_REQ_WRITE),
    .MEM_REQ_ADDRESS      (MEM_REQ_ADDRESS),
    .MEM_WRITE_DATA_VALID (MEM_WRITE_DATA_VALID),
    .MEM_WRITE_DATA       (MEM_WRITE_DATA),
    .MEM_WRITE_DATA_READY (MEM_WRITE_DATA_READY),
    .MEM_READ_DATA_VALID  (MEM_READ_DATA_VALID),
    .MEM_READ_DATA        (MEM_READ_DATA),
    .MEM_READ_LAST        (MEM_READ_LAST),
    .MEM_WRITE_DONE       (MEM_WRITE_DONE)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_mem [0:(1<<AW)-1];
  bit          known     [0:(1<<AW)-1];
  logic [31:0] wd [0:LW-1];
  int          wg [0:LW-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << AW));
  endfunction

  function automatic int lbase(input logic [31:0] a);
    return widx(a) - (widx(a) % LW);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (MEM_REQ_READY !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (MEM_REQ_READY !== 1'b1) check_val("ready_timeout", 32'(MEM_REQ_READY), 32'd1);
  endtask

  // Called just after the accepting edge k; returns at the idle cycle before edge k+LAT+LW.
  task automatic check_burst(input logic [31:0] a);
    int base;
    int start;
    int beat;
    int w;
    base  = lbase(a);
    start = 0;
    beat  = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    start = widx(a) % LW;
`endif
    for (int t = 0; t < LAT + LW; t++) begin
      if (t >= LAT - 1 && t <= LAT + LW - 2) begin
        w = base + ((start + beat) % LW);
        check_val("rd_valid", 32'(MEM_READ_DATA_VALID), 32'd1);
        check_val("rd_busy_ready", 32'(MEM_REQ_READY), 32'd0);
        if (known[w]) check_val("rd_data", MEM_READ_DATA, model_mem[w]);
        check_val("rd_last", 32'(MEM_READ_LAST), 32'(beat == LW - 1));
        beat++;
      end else if (t == LAT + LW - 1) begin
        check_val("rd_idle_ready", 32'(MEM_REQ_READY), 32'd1);
        check_val("rd_idle_valid", 32'(MEM_READ_DATA_VALID), 32'd0);
      end else begin
        check_val("rd_wait_valid", 32'(MEM_READ_DATA_VALID), 32'd0);
        check_val("rd_wait_data", MEM_READ_DATA, 32'd0);
        check_val("rd_wait_ready", 32'(MEM_REQ_READY), 32'd0);
      end
      if (t < LAT + LW - 1) tick();
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    wait_ready();
    MEM_REQ_VALID   = 1'b1;
    MEM_REQ_WRITE   = 1'b0;
    MEM_REQ_ADDRESS = a;
    tick();
    MEM_REQ_VALID   = 1'b0;
    MEM_REQ_ADDRESS = $urandom;
    check_burst(a);
  endtask

  task automatic do_write(input logic [31:0] a);
    int base;
    base = lbase(a);
    wait_ready();
    MEM_REQ_VALID   = 1'b1;
    MEM_REQ_WRITE   = 1'b1;
    MEM_REQ_ADDRESS = a;
    tick();
    MEM_REQ_VALID = 1'b0;
    MEM_REQ_WRITE = 1'b0;
    for (int b = 0; b < LW; b++) begin
      for (int g = 0; g < wg[b]; g++) begin
        check_val("wr_gap_ready", 32'(MEM_WRITE_DATA_READY), 32'd1);
        MEM_WRITE_DATA_VALID = 1'b0;
        MEM_WRITE_DATA       = $urandom;
        tick();
      end
      check_val("wr_ready", 32'(MEM_WRITE_DATA_READY), 32'd1);
      MEM_WRITE_DATA_VALID = 1'b1;
      MEM_WRITE_DATA       = wd[b];
      tick();
      model_mem[base + b] = wd[b];
      known[base + b]     = 1'b1;
    end
    MEM_WRITE_DATA_VALID = 1'b0;
    for (int t = 0; t <= LAT; t++) begin
      check_val("wr_done", 32'(MEM_WRITE_DONE), 32'(t == LAT - 1));
      check_val("wr_req_ready", 32'(MEM_REQ_READY), 32'(t == LAT));
      check_val("wr_data_ready", 32'(MEM_WRITE_DATA_READY), 32'd0);
      if (t < LAT) tick();
    end
  endtask

  task automatic check_all_low(input string tag);
    check_val({tag, "_req_ready"}, 32'(MEM_REQ_READY), 32'd0);
    check_val({tag, "_wd_ready"}, 32'(MEM_WRITE_DATA_READY), 32'd0);
    check_val({tag, "_rd_valid"}, 32'(MEM_READ_DATA_VALID), 32'd0);
    check_val({tag, "_rd_data"}, MEM_READ_DATA, 32'd0);
    check_val({tag, "_rd_last"}, 32'(MEM_READ_LAST), 32'd0);
    check_val({tag, "_wr_done"}, 32'(MEM_WRITE_DONE), 32'd0);
  endtask

  task automatic rand_line_data();
    for (int b = 0; b < LW; b++) begin
      wd[b] = $urandom;
      wg[b] = $urandom_range(0, 2);
    end
  endtask

  function automatic logic [31:0] rand_alias(input logic [31:0] a);
    return ($urandom & 32'hFFFF_C000) | a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) known[i] = 1'b0;
    RST                  = 1'b1;
    MEM_REQ_VALID        = 1'b0;
    MEM_REQ_WRITE        = 1'b0;
    MEM_REQ_ADDRESS      = 32'd0;
    MEM_WRITE_DATA_VALID = 1'b0;
    MEM_WRITE_DATA       = 32'd0;
    tick();
    tick();
    check_all_low("reset");
    RST = 1'b0;
    #1;
    check_val("ready_after_reset", 32'(MEM_REQ_READY), 32'd1);

    // Line at 0x40: write back-to-back, read plain and with word offset 2.
    for (int b = 0; b < LW; b++) begin
      wd[b] = 32'hA0A0_0000 + 32'(b);
      wg[b] = 0;
    end
    do_write(32'h40);
    do_read(32'h40);
    do_read(32'h48);

    // Line at 0x80 with stalls, then stray write beats while idle.
    for (int b = 0; b < LW; b++) wd[b] = 32'hB0B0_0000 + 32'(b);
    wg[0] = 0; wg[1] = 0; wg[2] = 2; wg[3] = 1;
    do_write(32'h80);
    for (int i = 0; i < 3; i++) begin
      MEM_WRITE_DATA_VALID = 1'b1;
      MEM_WRITE_DATA       = $urandom;
      check_val("idle_wd_ready", 32'(MEM_WRITE_DATA_READY), 32'd0);
      tick();
      MEM_WRITE_DATA_VALID = 1'b0;
      tick();
    end
    do_read(32'h80);

    // Request valid held across two reads.
    wait_ready();
    MEM_REQ_VALID   = 1'b1;
    MEM_REQ_WRITE   = 1'b0;
    MEM_REQ_ADDRESS = 32'h40;
    tick();
    MEM_REQ_ADDRESS = 32'h84;
    check_burst(32'h40);
    tick();
    MEM_REQ_VALID = 1'b0;
    check_burst(32'h84);

    // Reset after two beats of a write to 0xC0.
    for (int b = 0; b < LW; b++) begin
      wd[b] = 32'hC0C0_0000 + 32'(b);
      wg[b] = 0;
    end
    do_write(32'hC0);
    wait_ready();
    MEM_REQ_VALID   = 1'b1;
    MEM_REQ_WRITE   = 1'b1;
    MEM_REQ_ADDRESS = 32'hC0;
    tick();
    MEM_REQ_VALID = 1'b0;
    MEM_REQ_WRITE = 1'b0;
    for (int b = 0; b < 2; b++) begin
      MEM_WRITE_DATA_VALID = 1'b1;
      MEM_WRITE_DATA       = 32'hD0D0_0000 + 32'(b);
      tick();
      model_mem[lbase(32'hC0) + b] = 32'hD0D0_0000 + 32'(b);
    end
    MEM_WRITE_DATA = 32'hD0D0_0002;
    RST = 1'b1;
    #1;
    check_all_low("rst_wr");
    MEM_WRITE_DATA_VALID = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    check_val("rst_wr_release_ready", 32'(MEM_REQ_READY), 32'd1);
    do_read(32'hC0);

    // Reset while waiting on read latency.
    wait_ready();
    MEM_REQ_VALID   = 1'b1;
    MEM_REQ_WRITE   = 1'b0;
    MEM_REQ_ADDRESS = 32'h40;
    tick();
    MEM_REQ_VALID = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    #1;
    check_all_low("rst_rd");
    tick();
    RST = 1'b0;
    #1;
    for (int t = 0; t < LAT + LW; t++) begin
      check_val("rst_rd_no_beat", 32'(MEM_READ_DATA_VALID), 32'd0);
      tick();
    end
    do_read(32'h80);

    // Randomized traffic over eight lines, with aliased high address bits.
    for (int l = 0; l < 8; l++) begin
      rand_line_data();
      do_write(rand_alias(32'h400 + 32'(16 * l)));
    end
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = rand_alias(32'h400 + 32'(16 * $urandom_range(0, 7)) +
                     32'(4 * $urandom_range(0, LW - 1)) + 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        rand_line_data();
        do_write(a);
      end else begin
        do_read(a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
